// File: rtl/wb_arbiter_ctrl.sv
// Round-robin Wishbone arbiter: grants are held for a whole burst. A stall watchdog
// ends hung transfers with a one-cycle error and flushes the offending host.
module wb_arbiter_ctrl #(
  parameter int num_hosts      = 2,
  parameter int timeout_cycles = 255,
  localparam int sel_bits      = (num_hosts > 1) ? $clog2(num_hosts) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [num_hosts-1:0] wbm_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  input  logic                 wbs_rty_i,
  output logic [num_hosts-1:0] grant_o,
  output logic [sel_bits-1:0]  select_o,
  output logic                 active_o,
  output logic                 timeout_err_o,
  output logic [15:0]          tmo_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(timeout_cycles);
  localparam bit          TMO_EN    = (timeout_cycles != 0);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               r_state,    w_state_nx;
  logic [num_hosts-1:0] r_grant,    w_grant_nx;
  logic [sel_bits-1:0]  r_select,   w_select_nx;
  logic                 r_active,   w_active_nx;
  logic                 r_tmo_err,  w_tmo_err_nx;
  logic [15:0]          r_wdog,     w_wdog_nx;
  logic [15:0]          r_tmo_cnt,  w_tmo_cnt_nx;
  logic [sel_bits-1:0]  r_last,     w_last_nx;

  int                   w_dist;
  int                   w_best;
  logic                 w_found;
  logic [sel_bits-1:0]  w_winner;
  logic [num_hosts-1:0] w_winner_oh;
  logic                 w_owner_cyc;
  logic                 w_term;
  logic                 w_stall;
  logic                 w_arb;

  // Round-robin pick: the requester at the smallest circular distance after r_last wins.
  always_comb begin
    w_dist      = 0;
    w_best      = num_hosts;
    w_found     = 1'b0;
    w_winner    = '0;
    w_winner_oh = '0;
    for (int j = 0; j < num_hosts; j++) begin
      w_dist = j - int'(r_last) - 1;
      if (w_dist < 0) w_dist = w_dist + num_hosts;
      if (wbm_cyc_i[j] && (w_dist < w_best)) begin
        w_best         = w_dist;
        w_found        = 1'b1;
        w_winner       = sel_bits'(j);
        w_winner_oh    = '0;
        w_winner_oh[j] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_select_nx  = r_select;
    w_active_nx  = r_active;
    w_tmo_err_nx = 1'b0;
    w_wdog_nx    = '0;
    w_tmo_cnt_nx = r_tmo_cnt;
    w_last_nx    = r_last;
    w_arb        = 1'b0;
    w_owner_cyc  = |(wbm_cyc_i & r_grant);
    w_term       = wbs_ack_i | wbs_err_i | wbs_rty_i;
    w_stall      = wbs_stb_i & ~w_term;

    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_GRANT: begin
        if (!w_owner_cyc) begin
          w_arb = 1'b1;
        end else if (w_stall) begin
          // A termination in the limit cycle keeps w_stall low, so it always beats the timeout.
          if (TMO_EN && (({1'b0, r_wdog} + 17'd1) == TMO_LIMIT)) begin
            w_tmo_err_nx = 1'b1;
            w_state_nx   = S_FLUSH;
            w_active_nx  = 1'b0;
            w_tmo_cnt_nx = sat_inc16(r_tmo_cnt);
          end else begin
            w_wdog_nx = r_wdog + 16'd1;
          end
        end
      end
      S_FLUSH: begin
        if (!w_owner_cyc) w_arb = 1'b1;
      end
      default: w_arb = 1'b1;
    endcase

    // Shared handoff path: straight to the next winner, or idle with select held.
    if (w_arb) begin
      if (w_found) begin
        w_state_nx  = S_GRANT;
        w_grant_nx  = w_winner_oh;
        w_select_nx = w_winner;
        w_active_nx = 1'b1;
        w_last_nx   = w_winner;
      end else begin
        w_state_nx  = S_IDLE;
        w_grant_nx  = '0;
        w_active_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_select  <= '0;
      r_active  <= 1'b0;
      r_tmo_err <= 1'b0;
      r_wdog    <= '0;
      r_tmo_cnt <= '0;
      r_last    <= sel_bits'(num_hosts - 1);
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_select  <= w_select_nx;
      r_active  <= w_active_nx;
      r_tmo_err <= w_tmo_err_nx;
      r_wdog    <= w_wdog_nx;
      r_tmo_cnt <= w_tmo_cnt_nx;
      r_last    <= w_last_nx;
    end
  end

  assign grant_o       = r_grant;
  assign select_o      = r_select;
  assign active_o      = r_active;
  assign timeout_err_o = r_tmo_err;
  assign tmo_count_o   = r_tmo_cnt;

endmodule

// File: tb/tb_wb_arbiter_ctrl.sv
// Bench for wb_arbiter_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against an ownership-level reference model.
module tb_wb_arbiter_ctrl;

  localparam int N   = 3;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] cyc;
  logic         stb, ack, err, rty;
  logic [N-1:0] grant;
  logic [1:0]   sel;
  logic         active, terr;
  logic [15:0]  tcnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: who owns the bus, whether it is being flushed, etc.
  int m_owner, m_last, m_sel, m_stall, m_tmo;
  bit m_flush, m_err;

  wb_arbiter_ctrl #(.num_hosts(N), .timeout_cycles(TMO)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .wbm_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_ack_i    (ack),
    .wbs_err_i    (err),
    .wbs_rty_i    (rty),
    .grant_o      (grant),
    .select_o     (sel),
    .active_o     (active),
    .timeout_err_o(terr),
    .tmo_count_o  (tcnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_sel = 0; m_stall = 0; m_tmo = 0;
    m_flush = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    int cand;
    m_err = 1'b0;
    if (m_owner >= 0 && cyc[m_owner]) begin
      if (!m_flush) begin
        if (stb && !(ack || err || rty)) begin
          m_stall++;
          if (m_stall == TMO) begin
            m_err   = 1'b1;
            m_stall = 0;
            m_flush = 1'b1;
            if (m_tmo < 65535) m_tmo++;
          end
        end else begin
          m_stall = 0;
        end
      end
    end else begin
      m_stall = 0; m_flush = 1'b0; m_owner = -1; found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (!found && cyc[cand]) begin
          found = 1'b1; m_owner = cand;
        end
      end
      if (found) begin
        m_last = m_owner; m_sel = m_owner;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("grant",     int'(grant),  (m_owner >= 0) ? (1 << m_owner) : 0);
    check_eq("select",    int'(sel),    m_sel);
    check_eq("active",    int'(active), (m_owner >= 0 && !m_flush) ? 1 : 0);
    check_eq("tmo_err",   int'(terr),   int'(m_err));
    check_eq("tmo_count", int'(tcnt),   m_tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  int order[$];
  int idle_cnt, held, prev_owner;
  logic [N-1:0] prev_g;

  initial begin
    rst_n = 1'b1; cyc = '0; stb = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #11 compare_all();
    @(negedge clk) rst_n = 1'b1;

    // All hosts request; each holds its grant 4 cycles then drops for one.
    cyc = '1; held = 0; prev_owner = -1; idle_cnt = 0; prev_g = '0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c == 0) check_eq("first_grant", int'(grant), 1);
      if (grant == '0) idle_cnt++;
      else if (grant != prev_g) order.push_back(int'(sel));
      prev_g = grant;
      held = (m_owner == prev_owner) ? held + 1 : 1;
      prev_owner = m_owner;
      cyc = '1;
      if (held == 4) cyc[m_owner] = 1'b0;
    end
    check_eq("rr_count", order.size(), 4);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : -1, k % 3);
    check_eq("no_idle_gap", idle_cnt, 0);
    cyc = '0; tick(); tick();

    // Host 1 burst with ack each beat; host 0 requests mid-burst.
    cyc = 3'b010; stb = 1'b1; ack = 1'b1;
    tick();
    for (int b = 0; b < 8; b++) begin
      if (b == 2) cyc[0] = 1'b1;
      tick();
      check_eq("burst_hold", int'(grant), 3'b010);
    end
    cyc = 3'b001;
    tick();
    check_eq("burst_handoff", int'(grant), 3'b001);
    stb = 1'b0; ack = 1'b0; cyc = '0; tick(); tick();

    // Host 0 stalls with no termination until the watchdog fires.
    cyc = 3'b001; stb = 1'b1;
    tick();
    for (int s = 1; s <= 4; s++) begin
      tick();
      check_eq("tmo_pulse", int'(terr), (s == 4) ? 1 : 0);
    end
    check_eq("tmo_inactive", int'(active), 0);
    check_eq("tmo_cnt1", int'(tcnt), 1);
    check_eq("tmo_grant_held", int'(grant), 3'b001);
    tick();
    check_eq("tmo_one_cycle", int'(terr), 0);
    check_eq("flush_hold", int'(grant), 3'b001);
    tick();
    cyc = '0; stb = 1'b0;
    tick();
    check_eq("flush_release", int'(grant), 0);

    // Ack on the 4th stalled cycle beats the timeout.
    cyc = 3'b001; stb = 1'b1;
    tick(); tick(); tick(); tick();
    ack = 1'b1;
    tick();
    check_eq("ack_wins_err", int'(terr), 0);
    check_eq("ack_wins_cnt", int'(tcnt), 1);
    ack = 1'b0; cyc = '0; stb = 1'b0;
    tick();

    // Asynchronous reset in the middle of a grant.
    cyc = 3'b010; stb = 1'b1; ack = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk) rst_n = 1'b1;
    cyc = '1; stb = 1'b0; ack = 1'b0;
    tick();
    check_eq("post_reset_host0", int'(grant), 3'b001);
    cyc = '0; tick();

    // Preload the expiration counter near the top, then saturate it.
    force dut.r_tmo_cnt = 16'hFFFE;
    m_tmo = 16'hFFFE;
    tick(); tick();
    release dut.r_tmo_cnt;
    tick();
    for (int r = 0; r < 2; r++) begin
      cyc = 3'b001; stb = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      check_eq("sat_err", int'(terr), 1);
      check_eq("sat_cnt", int'(tcnt), 16'hFFFF);
      cyc = '0; stb = 1'b0;
      tick();
    end

    // Randomized traffic checked cycle by cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int h = 0; h < N; h++)
        if ($urandom_range(0, 5) == 0) cyc[h] = ~cyc[h];
      stb = ($urandom_range(0, 9) < 8);
      ack = ($urandom_range(0, 9) == 0);
      err = ($urandom_range(0, 39) == 0);
      rty = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
